// File: rtl/bus_arbiter_m2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_m2
// Purpose  : Grant controller for a shared serial bus with two master ports
//            and one slave port. Masters raise a bus request and hold it
//            for the whole transaction. Requests arriving together are
//            resolved round-robin. A grant is released when its request
//            drops. No new grant is issued until the slave reports ready.
//            msel steers the master-side bus mux.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : maximum consecutive grant cycles before a forced revoke
//                    (only used when ARB_TIMEOUT_EN is defined)
//   CNT_WIDTH      : width of the grant-cycle counter,
//                    TIMEOUT_CYCLES < 2**CNT_WIDTH
// Ports
//   clk        in   system clock, all state on the rising edge
//   rstn       in   asynchronous active-low reset
//   m1_breq    in   master 1 bus request
//   m2_breq    in   master 2 bus request
//   s_ready    in   slave idle / ready for a new transaction
//   m1_bgrant  out  master 1 grant (decoded from registered state)
//   m2_bgrant  out  master 2 grant (decoded from registered state)
//   msel       out  mux select, 0 = master 1, 1 = master 2 (registered)
//   bus_busy   out  high whenever the arbiter is not idle
//   timeout    out  one-cycle pulse on a forced revoke
// Configuration macro
//   ARB_TIMEOUT_EN : when defined, a grant held for TIMEOUT_CYCLES cycles is
//                    forcibly revoked. The revoked master stays ineligible
//                    until its request has been seen low. When undefined,
//                    a grant is held for as long as the request stays high
//                    and timeout is tied low.
// ============================================================================
module bus_arbiter_m2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_breq,
  input  logic m2_breq,
  input  logic s_ready,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic msel,
  output logic bus_busy,
  output logic timeout
);

  // --------------------------------------------------------------------------
  // Elaboration-time sanity check on the counter sizing.
  // --------------------------------------------------------------------------
  if ((TIMEOUT_CYCLES < 1) ||
      (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_WIDTH))) begin : g_bad_cfg
    $error("bus_arbiter_m2: TIMEOUT_CYCLES must be in 1 .. 2**CNT_WIDTH-1");
  end

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT1  = 2'd1,
    ST_GRANT2  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // last_grant encoding: which master most recently held the bus
  localparam logic LG_M1 = 1'b0;
  localparam logic LG_M2 = 1'b1;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   msel_q, msel_d;
  logic [1:0] elig;   // bit 0 = master 1, bit 1 = master 2

`ifdef ARB_TIMEOUT_EN
  // The counter holds (cycles already granted - 1), so the grant is revoked
  // on the edge that would start cycle TIMEOUT_CYCLES + 1.
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           mask_q, mask_d;
  logic                 timeout_q, timeout_d;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    msel_d       = msel_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    // A revoke mask clears once its master's request is sampled low.
    mask_d       = mask_q & {m2_breq, m1_breq};
    elig         = {m2_breq, m1_breq} & ~mask_q;
`else
    elig         = {m2_breq, m1_breq};
`endif

    case (state_q)
      ST_IDLE: begin
        // On a tie, the master that did not hold the bus last wins.
        if (elig[0] && (!elig[1] || (last_grant_q == LG_M2))) begin
          state_d = ST_GRANT1;
          msel_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (elig[1]) begin
          state_d = ST_GRANT2;
          msel_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_GRANT1: begin
        // The other master's request is ignored here: no preemption.
        if (!m1_breq) begin
          state_d      = ST_RELEASE;
          last_grant_d = LG_M1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d      = ST_RELEASE;
          last_grant_d = LG_M1;
          timeout_d    = 1'b1;
          mask_d[0]    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
`endif
      end

      ST_GRANT2: begin
        if (!m2_breq) begin
          state_d      = ST_RELEASE;
          last_grant_d = LG_M2;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d      = ST_RELEASE;
          last_grant_d = LG_M2;
          timeout_d    = 1'b1;
          mask_d[1]    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
`endif
      end

      ST_RELEASE: begin
        // Let the slave finish its serial transfer before re-arbitrating.
        if (s_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LG_M2;     // master 1 wins the first tie
      msel_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      mask_q       <= 2'b00;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      msel_q       <= msel_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded straight from registered state, so the grants are
  // mutually exclusive by construction and clear at once on reset.
  // --------------------------------------------------------------------------
  assign m1_bgrant = (state_q == ST_GRANT1);
  assign m2_bgrant = (state_q == ST_GRANT2);
  assign bus_busy  = (state_q != ST_IDLE);
  // msel only changes on grant entry, so it holds through RELEASE and IDLE.
  assign msel      = msel_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_m2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_m2
// Purpose  : Self-checking bench for bus_arbiter_m2. A behavioural model
//            tracks who owns the bus, whether the bus is draining, who won
//            last, the current select value and how long the current owner
//            has held the bus. Scenario tasks drive directed and random
//            stimulus and compare the DUT outputs against the model and
//            against hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_m2;

  localparam int TCYC = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic rstn    = 1'b0;
  logic m1_breq = 1'b0;
  logic m2_breq = 1'b0;
  logic s_ready = 1'b1;
  logic m1_bgrant, m2_bgrant, msel, bus_busy, timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_m2 #(
    .TIMEOUT_CYCLES(TCYC),
    .CNT_WIDTH     (8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .m1_breq  (m1_breq),
    .m2_breq  (m2_breq),
    .s_ready  (s_ready),
    .m1_bgrant(m1_bgrant),
    .m2_bgrant(m2_bgrant),
    .msel     (msel),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  // Output vector order: {m1_bgrant, m2_bgrant, msel, bus_busy, timeout}
  logic [4:0] dut_vec;
  logic [4:0] exp_vec;
  assign dut_vec = {m1_bgrant, m2_bgrant, msel, bus_busy, timeout};

  // --------------------------------------------------------------------------
  // Reference model
  // owner : 0 = nobody, 1 = master 1, 2 = master 2
  // rel   : bus is draining, waiting for the slave
  // held  : number of cycles the current owner has had the grant so far
  // --------------------------------------------------------------------------
  int mdl_owner = 0;
  bit mdl_rel   = 1'b0;
  int mdl_last  = 2;
  bit mdl_sel   = 1'b0;
  int mdl_held  = 0;
  bit mdl_mask1 = 1'b0;
  bit mdl_mask2 = 1'b0;
  bit mdl_pulse = 1'b0;
  bit nm1, nm2, e1, e2, own_req;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdl_owner = 0;
      mdl_rel   = 1'b0;
      mdl_last  = 2;
      mdl_sel   = 1'b0;
      mdl_held  = 0;
      mdl_mask1 = 1'b0;
      mdl_mask2 = 1'b0;
      mdl_pulse = 1'b0;
    end else begin
      mdl_pulse = 1'b0;
      nm1 = mdl_mask1 && m1_breq;
      nm2 = mdl_mask2 && m2_breq;
      if (mdl_owner != 0) begin
        own_req = (mdl_owner == 1) ? m1_breq : m2_breq;
        if (!own_req) begin
          mdl_last  = mdl_owner;
          mdl_owner = 0;
          mdl_rel   = 1'b1;
        end else if (TO_EN && (mdl_held == TCYC)) begin
          mdl_last = mdl_owner;
          if (mdl_owner == 1) nm1 = 1'b1;
          else                nm2 = 1'b1;
          mdl_pulse = 1'b1;
          mdl_owner = 0;
          mdl_rel   = 1'b1;
        end else begin
          mdl_held = mdl_held + 1;
        end
      end else if (mdl_rel) begin
        if (s_ready) mdl_rel = 1'b0;
      end else begin
        e1 = m1_breq && !mdl_mask1;
        e2 = m2_breq && !mdl_mask2;
        if (e1 && e2)  mdl_owner = (mdl_last == 1) ? 2 : 1;
        else if (e1)   mdl_owner = 1;
        else if (e2)   mdl_owner = 2;
        if (mdl_owner != 0) begin
          mdl_sel  = (mdl_owner == 2);
          mdl_held = 1;
        end
      end
      mdl_mask1 = nm1;
      mdl_mask2 = nm2;
    end
  end

  assign exp_vec = {mdl_owner == 1, mdl_owner == 2, mdl_sel,
                    (mdl_owner != 0) || mdl_rel, mdl_pulse};

  // Stimulus-only helper: pulse reset away from the clock edge.
  task automatic apply_reset();
    m1_breq = 1'b0;
    m2_breq = 1'b0;
    s_ready = 1'b1;
    rstn    = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    m1_breq = 1'b0; m2_breq = 1'b0; s_ready = 1'b1; rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== 5'b00000) begin
      bad++;
      $display("FAIL reset_asserted: got %b expected %b", dut_vec, 5'b00000);
    end
    rstn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL reset_idle: got %b expected %b", dut_vec, exp_vec);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single();
    m1_breq = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut_vec !== 5'b10010) begin
      bad++;
      $display("FAIL single_grant: got %b expected %b", dut_vec, 5'b10010);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 3) m1_breq = 1'b0;
      @(posedge clk); #1;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL single_seq[%0d]: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_tie();
    logic [4:0] want [0:2];
    apply_reset();
    m1_breq = 1'b1; m2_breq = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut_vec !== 5'b10010) begin
      bad++;
      $display("FAIL tie_first_m1: got %b expected %b", dut_vec, 5'b10010);
    end
    @(posedge clk); #1;
    m1_breq = 1'b0;
    // release edge, idle edge, then master 2 granted with msel=1
    want[0] = 5'b00010; want[1] = 5'b00000; want[2] = 5'b01110;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== want[i]) begin
        bad++;
        $display("FAIL tie_handover[%0d]: got %b expected %b", i, dut_vec, want[i]);
      end
    end
    m2_breq = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL tie_drain: got %b expected %b", dut_vec, exp_vec);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Both masters keep asking; each drops its request after two granted
  // cycles and re-asks immediately. Winners must alternate.
  task automatic test_fairness();
    int h1, h2, prev_winner, grants;
    bit p1, p2;
    apply_reset();
    h1 = 0; h2 = 0; prev_winner = 0; grants = 0; p1 = 1'b0; p2 = 1'b0;
    m1_breq = 1'b1; m2_breq = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL fair_cycle[%0d]: got %b expected %b", c, dut_vec, exp_vec);
      end
      if ((m1_bgrant && !p1) || (m2_bgrant && !p2)) begin
        grants++;
        total++;
        if (prev_winner == (m1_bgrant ? 1 : 2)) begin
          bad++;
          $display("FAIL fair_alternate: got winner %0d twice in a row", prev_winner);
        end
        prev_winner = m1_bgrant ? 1 : 2;
      end
      p1 = m1_bgrant; p2 = m2_bgrant;
      h1 = m1_bgrant ? h1 + 1 : 0;
      h2 = m2_bgrant ? h2 + 1 : 0;
      m1_breq = (h1 < 2);
      m2_breq = (h2 < 2);
    end
    total++;
    if (grants < 10) begin
      bad++;
      $display("FAIL fair_grant_count: got %0d expected at least %0d", grants, 10);
    end
    m1_breq = 1'b0; m2_breq = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stall();
    apply_reset();
    m1_breq = 1'b1;
    @(posedge clk); #1;
    m1_breq = 1'b0; m2_breq = 1'b1; s_ready = 1'b0;
    @(posedge clk); #1;
    m1_breq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dut_vec !== 5'b00010) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got %b expected %b", i, dut_vec, 5'b00010);
      end
      @(posedge clk); #1;
    end
    // the edge above still saw s_ready=0; now let the slave go
    s_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut_vec !== 5'b00000) begin
      bad++;
      $display("FAIL stall_idle: got %b expected %b", dut_vec, 5'b00000);
    end
    @(posedge clk); #1;
    total++;
    if (dut_vec !== 5'b01110) begin
      bad++;
      $display("FAIL stall_regrant: got %b expected %b", dut_vec, 5'b01110);
    end
    m1_breq = 1'b0; m2_breq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_timeout();
    int m1_hi, pulses, m2_seen, regrant;
    apply_reset();
    m1_hi = 0; pulses = 0; m2_seen = 0; regrant = 0;
    m1_breq = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      m2_breq = 1'b1;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL to_cycle[%0d]: got %b expected %b", c, dut_vec, exp_vec);
      end
      if (m1_bgrant) m1_hi++;
      if (timeout)   pulses++;
      if (m2_bgrant) m2_seen = 1;
    end
    total++;
    if (m1_hi != (TO_EN ? TCYC : 20)) begin
      bad++;
      $display("FAIL to_m1_cycles: got %0d expected %0d", m1_hi, TO_EN ? TCYC : 20);
    end
    // master 1 revoked after 8, master 2 granted 2 edges later and revoked
    // after its own 8 cycles, both inside the 20-cycle window
    total++;
    if (pulses != (TO_EN ? 2 : 0)) begin
      bad++;
      $display("FAIL to_pulses: got %0d expected %0d", pulses, TO_EN ? 2 : 0);
    end
    total++;
    if (m2_seen != (TO_EN ? 1 : 0)) begin
      bad++;
      $display("FAIL to_m2_next: got %0d expected %0d", m2_seen, TO_EN ? 1 : 0);
    end
    m1_breq = 1'b0; m2_breq = 1'b0;
    @(posedge clk); #1;
    m1_breq = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL to_after[%0d]: got %b expected %b", c, dut_vec, exp_vec);
      end
      if (m1_bgrant) regrant = 1;
    end
    total++;
    if (regrant != 1) begin
      bad++;
      $display("FAIL to_m1_regrant: got %0d expected %0d", regrant, 1);
    end
    m1_breq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    apply_reset();
    m2_breq = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut_vec !== 5'b01110) begin
      bad++;
      $display("FAIL arst_grant2: got %b expected %b", dut_vec, 5'b01110);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (dut_vec !== 5'b00000) begin
      bad++;
      $display("FAIL arst_clear: got %b expected %b", dut_vec, 5'b00000);
    end
    #1;
    rstn = 1'b1;
    m1_breq = 1'b1; m2_breq = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dut_vec !== 5'b10010) begin
      bad++;
      $display("FAIL arst_tie_m1: got %b expected %b", dut_vec, 5'b10010);
    end
    m1_breq = 1'b0; m2_breq = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL arst_drain: got %b expected %b", dut_vec, exp_vec);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      m1_breq = ($urandom_range(0, 3) != 0);
      m2_breq = ($urandom_range(0, 3) != 0);
      s_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++;
        $display("FAIL rand[%0d]: got %b expected %b", c, dut_vec, exp_vec);
      end
    end
    m1_breq = 1'b0; m2_breq = 1'b0; s_ready = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_stall();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
